fifo_uart_tx_drain: RTL and testbench

Downstream consumer for the team FIFO (fifo_fl / fifo_fe style flags). It watches fifo_empty, reads the head word on fifo_data, and pulses fifo_drop for exactly one clock per word. Each word is serialised as an asynchronous UART frame on tx. It sits between a buffered data source and the board UART pin, and keeps a level-sensitive drop from over-reading the FIFO.

---
 rtl/fifo_uart_tx_drain.sv | 192 +++++++++++++++++++
 tb/tb_fifo_uart_tx_drain.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx_drain.sv
// UART transmitter that drains a FIFO one word per frame.
// It issues a single-cycle drop per consumed word and serialises the word LSB first.
module fifo_uart_tx_drain #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_drop,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    generate
        if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_width
            $error("fifo_uart_tx_drain: DATA_WIDTH must be 5..9");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
            $error("fifo_uart_tx_drain: STOP_BITS must be 1 or 2");
        end
        if (CLKS_PER_BIT < 2) begin : g_bad_cpb
            $error("fifo_uart_tx_drain: CLKS_PER_BIT must be >= 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       IDX_LAST  = 4'(DATA_WIDTH - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic             PAR_ODD   = 1'(PARITY_ODD);

    function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [3:0]            idx_q, idx_d;
    logic                  stop_q, stop_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  par_q, par_d;
    logic                  tx_q, tx_d;
    logic                  drop_q, drop_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  bit_end_s;

    assign bit_end_s = (cnt_q == CNT_LAST);

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        stop_d  = stop_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        drop_d  = 1'b0;
        done_d  = 1'b0;
        if (bit_end_s) begin
            cnt_d = {CNT_W{1'b0}};
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                cnt_d  = {CNT_W{1'b0}};
                idx_d  = 4'd0;
                stop_d = 1'b0;
                // fifo_empty is only looked at here, so a stale flag after the drop cannot re-trigger
                if (enable && !fifo_empty) begin
                    shreg_d = fifo_data;
                    par_d   = calc_parity(fifo_data, PAR_ODD);
                    drop_d  = 1'b1;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_START;
                end else begin
                    tx_d   = 1'b1;
                    busy_d = 1'b0;
                end
            end
            S_START: begin
                if (bit_end_s) begin
                    tx_d    = shreg_q[0];
                    state_d = S_DATA;
                end else begin
                    tx_d = 1'b0;
                end
            end
            S_DATA: begin
                if (bit_end_s) begin
                    if (idx_q == IDX_LAST) begin
                        idx_d = 4'd0;
                        if (PARITY_EN != 0) begin
                            tx_d    = par_q;
                            state_d = S_PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = S_STOP;
                        end
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        shreg_d = shreg_q >> 1;
                        tx_d    = shreg_q[1];
                    end
                end else begin
                    tx_d = shreg_q[0];
                end
            end
            S_PARITY: begin
                if (bit_end_s) begin
                    tx_d    = 1'b1;
                    state_d = S_STOP;
                end else begin
                    tx_d = par_q;
                end
            end
            S_STOP: begin
                tx_d = 1'b1;
                if (bit_end_s) begin
                    if (stop_q == STOP_LAST) begin
                        stop_d  = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        stop_d = stop_q + 1'b1;
                    end
                end else begin
                    stop_d = stop_q;
                end
            end
            default: begin
                cnt_d   = {CNT_W{1'b0}};
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            idx_q   <= 4'd0;
            stop_q  <= 1'b0;
            shreg_q <= {DATA_WIDTH{1'b0}};
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            drop_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            stop_q  <= stop_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            drop_q  <= drop_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign fifo_drop  = drop_q;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_fifo_uart_tx_drain.sv
// Directed bench for fifo_uart_tx_drain with CLKS_PER_BIT=4 and a small FIFO model.
module tb_fifo_uart_tx_drain;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_drop, tx, busy, frame_done;

    logic       p_en = 1'b0;
    logic       p_empty = 1'b1;
    logic [7:0] p_data = 8'h07;
    logic       pe_drop, pe_tx, pe_busy, pe_done;
    logic       po_drop, po_tx, po_busy, po_done;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fifo_uart_tx_drain #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0),
                         .PARITY_ODD(0), .STOP_BITS(1)) dut (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_drop(fifo_drop), .tx(tx), .busy(busy),
        .frame_done(frame_done));

    fifo_uart_tx_drain #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1),
                         .PARITY_ODD(0), .STOP_BITS(1)) dut_pe (
        .clk(clk), .rst(rst), .enable(p_en), .fifo_empty(p_empty),
        .fifo_data(p_data), .fifo_drop(pe_drop), .tx(pe_tx), .busy(pe_busy),
        .frame_done(pe_done));

    fifo_uart_tx_drain #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1),
                         .PARITY_ODD(1), .STOP_BITS(1)) dut_po (
        .clk(clk), .rst(rst), .enable(p_en), .fifo_empty(p_empty),
        .fifo_data(p_data), .fifo_drop(po_drop), .tx(po_tx), .busy(po_busy),
        .frame_done(po_done));

    // Upstream FIFO model: pops on the edge after a drop.
    logic [7:0] mem [0:15];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty = (rd_ptr == wr_ptr);
    assign fifo_data  = mem[rd_ptr[3:0]];

    // Pop the head entry when the DUT drops it.
    always @(posedge clk) begin
        if (fifo_drop && !fifo_empty) rd_ptr <= rd_ptr + 1;
    end

    int cyc = 0;
    int drop_cnt = 0;
    int done_cnt = 0;
    int drop_prev = 0;
    int drop_last = 0;

    // Count drops and frame_done pulses and timestamp the drops.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_drop === 1'b1) begin
            drop_cnt  <= drop_cnt + 1;
            drop_prev <= drop_last;
            drop_last <= cyc;
        end
        if (frame_done === 1'b1) done_cnt <= done_cnt + 1;
    end

    logic exp_s [0:255];
    int   exp_n = 0;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        mem[wr_ptr[3:0]] = d;
        wr_ptr++;
    endtask

    task automatic add_frame(input logic [7:0] d);
        logic [9:0] b;
        b = {1'b1, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < CPB; k++) begin
                exp_s[exp_n] = b[i];
                exp_n++;
            end
        end
    endtask

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) begin
            exp_s[exp_n] = 1'b1;
            exp_n++;
        end
    endtask

    // Samples tx once per clock against the expected stream, starting at the current negedge.
    task automatic run_stream(output int bad, output int busy_n, output int drops, output int gap);
        int run;
        bad = 0; busy_n = 0; drops = 0; gap = 0; run = 0;
        for (int i = 0; i < exp_n; i++) begin
            if (tx !== exp_s[i]) bad++;
            if (busy === 1'b1) busy_n++;
            if (fifo_drop === 1'b1) drops++;
            if (tx === 1'b1) begin
                run++;
            end else begin
                if (run > 0) gap = run;
                run = 0;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int bad, bn, dr, gp, cnt0, pe_bit, po_bit, pe_bn, po_bn;

        // Reset state
        rst = 1'b1; enable = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_drop", 32'(fifo_drop), 32'd0);
        check("reset_done", 32'(frame_done), 32'd0);

        // Empty FIFO with enable high
        rst = 1'b0; enable = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (tx !== 1'b1 || busy !== 1'b0 || fifo_drop !== 1'b0) bad++;
            @(negedge clk);
        end
        check("empty_idle", 32'(bad), 32'd0);
        check("empty_drops", 32'(drop_cnt), 32'd0);

        // Basic frame 0xA5
        push(8'hA5);
        @(negedge clk);
        check("basic_start_drop", 32'(fifo_drop), 32'd1);
        exp_n = 0; add_frame(8'hA5);
        run_stream(bad, bn, dr, gp);
        check("basic_stream", 32'(bad), 32'd0);
        check("basic_busy_len", 32'(bn), 32'd40);
        check("basic_drop_len", 32'(dr), 32'd1);
        check("basic_done", 32'(frame_done), 32'd1);
        check("basic_busy_fall", 32'(busy), 32'd0);
        @(negedge clk);
        check("basic_done_width", 32'(frame_done), 32'd0);
        check("basic_done_cnt", 32'(done_cnt), 32'd1);

        // Back-to-back 0x01 then 0xFF
        push(8'h01); push(8'hFF);
        @(negedge clk);
        exp_n = 0; add_frame(8'h01); add_idle(1); add_frame(8'hFF);
        run_stream(bad, bn, dr, gp);
        check("b2b_stream", 32'(bad), 32'd0);
        check("b2b_drops", 32'(dr), 32'd2);
        check("b2b_gap", 32'(gp), 32'd5);
        check("b2b_drop_spacing", 32'(drop_last - drop_prev), 32'd41);
        repeat (10) @(negedge clk);
        check("b2b_fifo_empty", 32'(fifo_empty), 32'd1);
        check("b2b_drop_total", 32'(drop_cnt), 32'd3);
        check("b2b_idle_busy", 32'(busy), 32'd0);

        // Parity on 0x07, even and odd
        p_en = 1'b1; p_empty = 1'b0;
        @(negedge clk);
        check("par_even_drop", 32'(pe_drop), 32'd1);
        check("par_odd_drop", 32'(po_drop), 32'd1);
        p_empty = 1'b1;
        pe_bit = 0; po_bit = 0; pe_bn = 0; po_bn = 0;
        for (int i = 0; i < 50; i++) begin
            if (i == 37) begin
                pe_bit = int'(pe_tx);
                po_bit = int'(po_tx);
            end
            if (pe_busy === 1'b1) pe_bn++;
            if (po_busy === 1'b1) po_bn++;
            @(negedge clk);
        end
        p_en = 1'b0;
        check("par_even_bit", 32'(pe_bit), 32'd1);
        check("par_odd_bit", 32'(po_bit), 32'd0);
        check("par_even_len", 32'(pe_bn), 32'd44);
        check("par_odd_len", 32'(po_bn), 32'd44);

        // Flow control: enable low holds off the start
        enable = 1'b0;
        push(8'h3C);
        cnt0 = drop_cnt; bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (tx !== 1'b1 || fifo_drop !== 1'b0) bad++;
            @(negedge clk);
        end
        check("flow_hold", 32'(bad), 32'd0);
        check("flow_no_drop", 32'(drop_cnt), 32'(cnt0));
        enable = 1'b1;
        @(negedge clk);
        check("flow_start_tx", 32'(tx), 32'd0);
        check("flow_start_drop", 32'(fifo_drop), 32'd1);
        enable = 1'b0;
        push(8'h55);
        exp_n = 0; add_frame(8'h3C);
        run_stream(bad, bn, dr, gp);
        check("flow_stream", 32'(bad), 32'd0);
        check("flow_busy_len", 32'(bn), 32'd40);
        check("flow_done", 32'(frame_done), 32'd1);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (tx !== 1'b1 || fifo_drop !== 1'b0) bad++;
            @(negedge clk);
        end
        check("flow_blocked", 32'(bad), 32'd0);
        check("flow_pending", 32'(fifo_empty), 32'd0);

        // Reset during data bit 3 of 0x55
        enable = 1'b1;
        @(negedge clk);
        check("rst_frame_start", 32'(tx), 32'd0);
        repeat (17) @(negedge clk);
        check("rst_pre_tx", 32'(tx), 32'd0);
        cnt0 = done_cnt;
        rst = 1'b1;
        @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_drop", 32'(fifo_drop), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
            @(negedge clk);
        end
        check("rst_quiet", 32'(bad), 32'd0);
        check("rst_no_done", 32'(done_cnt), 32'(cnt0));

        // New frame after reset release
        push(8'h81);
        @(negedge clk);
        exp_n = 0; add_frame(8'h81);
        run_stream(bad, bn, dr, gp);
        check("rst_restart_stream", 32'(bad), 32'd0);
        check("rst_restart_drops", 32'(dr), 32'd1);
        check("rst_restart_done", 32'(frame_done), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
